// File: rtl/accel_tb_pkg.sv
// Shared types and constants for the accelerator run/check controller.
package accel_tb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 32;

    // Cycles to let the accelerator's final SRAM writes land before reading back.
    localparam int unsigned DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StRunReq,
        StRunWait,
        StDrain,
        StCheck,
        StFin
    } state_e;

endpackage

// File: rtl/sram_compare_engine.sv
// Walks the result and golden SRAMs in lockstep, one address per cycle, and
// counts words whose 1-cycle-latency read data match.
module sram_compare_engine
    import accel_tb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter int unsigned       NUM_RESULTS = 32,
    parameter logic [ADDR_W-1:0] RESULT_BASE = '0,
    parameter logic [ADDR_W-1:0] GOLDEN_BASE = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              go_i,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [ADDR_W-1:0] gold_addr_o,
    input  logic [DATA_W-1:0] res_data_i,
    input  logic [DATA_W-1:0] gold_data_i,
    output logic [ADDR_W:0]   count_o,
    output logic              finished_o
);

    typedef logic [ADDR_W:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NUM_RESULTS - 1);

    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [ADDR_W-1:0] gold_addr_q, gold_addr_d;
    idx_t              idx_q, idx_d;
    idx_t              count_q, count_d;
    logic              issue_q, issue_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              fin_q, fin_d;

    // Address issue, compare pipeline and match counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            res_addr_q  <= '0;
            gold_addr_q <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            issue_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            res_addr_q  <= res_addr_d;
            gold_addr_q <= gold_addr_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            issue_q     <= issue_d;
            cmp_vld_q   <= cmp_vld_d;
            fin_q       <= fin_d;
        end
    end

    // Data returns the cycle after its address; finish fires once the last count has settled.
    always_comb begin
        res_addr_d  = res_addr_q;
        gold_addr_d = gold_addr_q;
        idx_d       = idx_q;
        count_d     = count_q;
        issue_d     = issue_q;
        cmp_vld_d   = issue_q;
        fin_d       = cmp_vld_q && !issue_q;

        if (go_i) begin
            res_addr_d  = RESULT_BASE;
            gold_addr_d = GOLDEN_BASE;
            idx_d       = '0;
            issue_d     = 1'b1;
        end else if (issue_q) begin
            if (idx_q == LAST_IDX) begin
                issue_d = 1'b0;
            end else begin
                idx_d       = idx_q + idx_t'(1);
                res_addr_d  = res_addr_q + ADDR_W'(1);
                gold_addr_d = gold_addr_q + ADDR_W'(1);
            end
        end

        if (cmp_vld_q && (res_data_i == gold_data_i)) begin
            count_d = count_q + idx_t'(1);
        end
        if (clr_i || go_i) begin
            count_d = '0;
        end
    end

    assign res_addr_o  = res_addr_q;
    assign gold_addr_o = gold_addr_q;
    assign count_o     = count_q;
    assign finished_o  = fin_q;

endmodule

// File: rtl/accel_run_checker.sv
// Host-side round controller: waits for the accelerator to go idle, pulses run,
// times the compute phase, then checks the output SRAM against a golden copy.
module accel_run_checker
    import accel_tb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter int unsigned       NUM_RESULTS = 32,
    parameter logic [ADDR_W-1:0] RESULT_BASE = '0,
    parameter logic [ADDR_W-1:0] GOLDEN_BASE = '0,
    parameter int unsigned       TIMEOUT_CYC = 65535,
    parameter int unsigned       CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              dut_run,
    input  logic              dut_busy,
    output logic [ADDR_W-1:0] res_read_address,
    input  logic [DATA_W-1:0] res_read_data,
    output logic [ADDR_W-1:0] gold_read_address,
    input  logic [DATA_W-1:0] gold_read_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W:0]   correct_count,
    output logic [CNT_W-1:0]  compute_cycles
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
    typedef logic [WAIT_W-1:0] wait_t;
    typedef logic [ADDR_W:0]   cnt_t;
    localparam wait_t WAIT_LAST  = wait_t'(TIMEOUT_CYC - 1);
    localparam wait_t DRAIN_LAST = wait_t'(DRAIN_CYC - 1);
    localparam cnt_t  NUM_FULL   = cnt_t'(NUM_RESULTS);

    state_e           state_q, state_d;
    wait_t            wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] compute_q, compute_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             wait_hit;
    logic             cmp_go, cmp_clr, cmp_fin;
    cnt_t             cmp_count;

    // State and held-result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            compute_q  <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            compute_q  <= compute_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wait_hit = (wait_cnt_q == WAIT_LAST);

    // Next-state logic; the wait counter restarts on every state change.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        compute_d  = compute_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;

        // Compute-cycle counter saturates instead of wrapping.
        if ((state_q == StRunReq) || (state_q == StRunWait)) begin
            cyc_cnt_d = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StWaitIdle;
                    wait_cnt_d = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    compute_d  = '0;
                end
            end
            StWaitIdle: begin
                if (!dut_busy) begin
                    state_d    = StRunReq;
                    wait_cnt_d = '0;
                    cyc_cnt_d  = '0;
                end else if (wait_hit) begin
                    state_d   = StFin;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + wait_t'(1);
                end
            end
            StRunReq: begin
                // Only a sampled busy=1 acknowledges the run request.
                if (dut_busy) begin
                    state_d    = StRunWait;
                    wait_cnt_d = '0;
                end else if (wait_hit) begin
                    state_d   = StFin;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + wait_t'(1);
                end
            end
            StRunWait: begin
                if (!dut_busy) begin
                    state_d    = StDrain;
                    wait_cnt_d = '0;
                    compute_d  = cyc_cnt_q;
                end else if (wait_hit) begin
                    state_d   = StFin;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + wait_t'(1);
                end
            end
            StDrain: begin
                if (wait_cnt_q == DRAIN_LAST) begin
                    state_d    = StCheck;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + wait_t'(1);
                end
            end
            StCheck: begin
                // Pass is resolved on entry to FIN so it is valid alongside done.
                if (cmp_fin) begin
                    state_d = StFin;
                    pass_d  = (cmp_count == NUM_FULL) && !timeout_q;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        dut_run = (state_q == StRunReq);
        done    = (state_q == StFin);
        cmp_go  = (state_q == StDrain) && (wait_cnt_q == DRAIN_LAST);
        cmp_clr = (state_q == StIdle) && start;
    end

    sram_compare_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_RESULTS (NUM_RESULTS),
        .RESULT_BASE (RESULT_BASE),
        .GOLDEN_BASE (GOLDEN_BASE)
    ) u_cmp (
        .clk_i       (clk),
        .reset_i     (reset),
        .clr_i       (cmp_clr),
        .go_i        (cmp_go),
        .res_addr_o  (res_read_address),
        .gold_addr_o (gold_read_address),
        .res_data_i  (res_read_data),
        .gold_data_i (gold_read_data),
        .count_o     (cmp_count),
        .finished_o  (cmp_fin)
    );

    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign correct_count  = cmp_count;
    assign compute_cycles = compute_q;

endmodule

// File: doc/accel_run_checker.md
Name: accel_run_checker

Overview:
- Host-side initiator of the accelerator run/busy handshake.
- Waits for the accelerator to be idle, then pulses it to run. Measures compute cycles from run assertion to busy deassertion.
- After the run, reads the output SRAM back and compares each word against a golden SRAM. Reports a correct-word count and pass/fail.
- Sits beside MyDesign as a synthesizable replacement for the software round-control and checking loop.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM data width.
- NUM_RESULTS, 32, words to compare (1..2^ADDR_W).
- RESULT_BASE, 12'h000, first output-SRAM address to check.
- GOLDEN_BASE, 12'h000, first golden-SRAM address.
- TIMEOUT_CYC, 65535, maximum cycles allowed in any wait state.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a round; ignored unless in IDLE.
- dut_run  out  1  run request to the accelerator.
- dut_busy  in  1  accelerator busy.
- res_read_address  out  ADDR_W  output-SRAM read address.
- res_read_data  in  DATA_W  output-SRAM read data; 1-cycle latency.
- gold_read_address  out  ADDR_W  golden-SRAM read address.
- gold_read_data  in  DATA_W  golden-SRAM read data; 1-cycle latency.
- done  out  1  one-cycle pulse when a round finishes, including on timeout.
- pass  out  1  held; 1 when correct_count == NUM_RESULTS and no timeout occurred.
- timeout  out  1  held; set when any wait exceeds TIMEOUT_CYC.
- correct_count  out  ADDR_W+1  held; number of matching words.
- compute_cycles  out  CNT_W  held; cycles from dut_run rise to first dut_busy==0 after busy was seen.

Behaviour:
- Reset values:
  - dut_run=0, done=0, pass=0, timeout=0.
  - correct_count=0, compute_cycles=0.
  - Both read addresses = 0.
  - State = IDLE; all internal counters = 0.
- Reset mid-round: aborts the round immediately. dut_run drops on the next edge.
- States:
  - IDLE: on start, clear pass/timeout/correct_count/compute_cycles and go to WAIT_IDLE.
  - WAIT_IDLE: when dut_busy==0, set dut_run=1, zero the cycle counter, go to RUN_REQ.
  - RUN_REQ: dut_run held 1; counter increments every cycle. When dut_busy==1 is sampled, drop dut_run on the same edge and go to RUN_WAIT.
  - RUN_WAIT: counter increments. When dut_busy==0 is sampled, latch compute_cycles = counter, go to DRAIN.
  - DRAIN: wait 2 cycles for the accelerator's final SRAM writes to land, then go to CHECK.
  - CHECK: pipelined compare.
    - Cycle k (0..NUM_RESULTS-1): drive res_read_address = RESULT_BASE+k and gold_read_address = GOLDEN_BASE+k.
    - Cycle k+1: compare the returned data; increment correct_count on equality.
    - Issue one address per cycle.
    - Addresses wrap modulo 2^ADDR_W.
    - Last compare occurs NUM_RESULTS+1 cycles after CHECK entry; then go to FIN.
  - FIN: assert done for one cycle, evaluate pass, return to IDLE.
- Timeout:
  - A single wait counter, reset on entry to each of WAIT_IDLE, RUN_REQ, RUN_WAIT.
  - If it reaches TIMEOUT_CYC: set timeout=1, force dut_run=0, skip CHECK, go to FIN.
  - On timeout, pass=0 and correct_count=0.
- Busy already 1 during RUN_REQ's first cycle: accepted. dut_run is high exactly 1 cycle.
- dut_busy glitching to 0 in RUN_REQ: ignored; only busy==1 advances.
- start while not in IDLE: ignored. start in the same cycle as done: ignored (state is FIN, not IDLE).
- compute_cycles saturates at all-ones and does not wrap.
- correct_count width covers NUM_RESULTS = 2^ADDR_W.

Decomposition:
- Package accel_tb_pkg:
  - State enum: IDLE, WAIT_IDLE, RUN_REQ, RUN_WAIT, DRAIN, CHECK, FIN.
  - DRAIN_CYC = 2.
  - Shared address/data width constants.
- One sub-module: sram_compare_engine.
  - Address generator plus 1-cycle-latency compare pipeline and match counter.
  - Started by a go pulse; returns a finished pulse.

Test Plan:
- Nominal round: accelerator model holds busy 100 cycles after run; 32 matching words → dut_run high 1 cycle, compute_cycles=101 (run-rise to busy-low sample), correct_count=32, pass=1, done pulses once.
- Mismatch: corrupt words 0, 17, 31 in the output SRAM → correct_count=29, pass=0, timeout=0.
- Busy at start: dut_busy=1 for 40 cycles before start → dut_run stays 0 until busy falls, then rises the next edge.
- Timeout: TIMEOUT_CYC=50, busy never rises → timeout=1 and done at the 50th RUN_REQ cycle, dut_run=0, pass=0, no SRAM reads issued.
- Address wrap: RESULT_BASE=12'hFFE, NUM_RESULTS=4 → read addresses FFE, FFF, 000, 001; correct_count=4 with matching data.
- Reset mid-run: assert reset during RUN_WAIT → next cycle all outputs at reset values; a following start runs a clean round with pass=1.
